cp0: RTL

- Coprocessor-0 exception/interrupt controller; the counterpart that drives the fetch unit's redirect interface.
- Samples the memory-stage instruction's PC, exception code and branch-delay flag, plus the external hardware interrupt lines.
- Decides whether an exception or interrupt is taken, and asserts the one-cycle redirect request.
- Holds the return address supplied to the fetch unit on eret; serves mtc0/mfc0 register accesses.

---
 rtl/cp0_pkg.sv | 32 +++
 rtl/cp0_timer.sv | 38 +++
 rtl/cp0.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes.
// Pure constants and helpers; no timing or flow-control content.
// Imported by cp0 and cp0_timer.
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_BD     = 31;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with a sticky match flag feeding interrupt line 5.
// Latency: all updates one edge after the cause; no backpressure (free-running).
// Only instantiated when CP0_COUNT_EN is defined.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_pend
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            compare    <= '0;
            timer_pend <= 1'b0;
        end else begin
            if (wr_en && addr == REG_COUNT)
                count <= wdata;
            else
                count <= count + 32'd1;

            // A Compare write acknowledges the timer, even on a matching cycle.
            if (wr_en && addr == REG_COMPARE) begin
                compare    <= wdata;
                timer_pend <= 1'b0;
            end else if (count == compare && compare != 32'd0) begin
                timer_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0.sv
// Coprocessor-0 exception/interrupt controller; optional Count/Compare timer via CP0_COUNT_EN.
// Latency: req and rdata combinational; SR/Cause/EPC update on the next edge.
// Backpressure: none; a taken exception overrides any same-cycle mtc0.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID      = 32'h2021_0001,
    parameter int          EXCCODE_W = 5
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [4:0]           addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    input  logic [31:0]          pc_in,
    input  logic                 bd_in,
    input  logic [EXCCODE_W-1:0] exccode_in,
    input  logic [5:0]           hwint,
    input  logic                 eret,
    output logic                 req,
    output logic [31:0]          epc_out,
    output logic                 exl_out
);

    logic [5:0]           sr_im;
    logic                 sr_exl;
    logic                 sr_ie;
    logic                 cause_bd;
    logic [5:0]           cause_ip;
    logic [EXCCODE_W-1:0] cause_exc;
    logic [31:0]          epc;
    logic [5:0]           ip_next;
    logic                 int_req;
    logic                 exc_req;
    logic                 wr_ok;

    assign int_req = (|(cause_ip & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = (exccode_in != '0) & ~sr_exl;
    assign req     = int_req | exc_req;
    assign wr_ok   = we & ~req;
    assign epc_out = epc;
    assign exl_out = sr_exl;

`ifdef CP0_COUNT_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_pend;

    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_ok),
        .addr       (addr),
        .wdata      (wdata),
        .count      (count),
        .compare    (compare),
        .timer_pend (timer_pend)
    );

    assign ip_next = {hwint[5] | timer_pend, hwint[4:0]};
`else
    assign ip_next = hwint;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= ip_next;
            if (req) begin
                sr_exl    <= 1'b1;
                cause_exc <= int_req ? EXC_INT[EXCCODE_W-1:0] : exccode_in;
                cause_bd  <= bd_in;
                epc       <= align_word(bd_in ? pc_in - 32'd4 : pc_in);
            end else begin
                // eret's EXL clear beats an mtc0 that writes EXL in the same cycle.
                if (wr_ok && addr == REG_SR) begin
                    sr_im  <= wdata[SR_IM_LO +: 6];
                    sr_ie  <= wdata[SR_IE];
                    sr_exl <= wdata[SR_EXL] & ~eret;
                end else if (eret) begin
                    sr_exl <= 1'b0;
                end
                if (wr_ok && addr == REG_EPC)
                    epc <= align_word(wdata);
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            REG_SR: begin
                rdata[SR_IM_LO +: 6] = sr_im;
                rdata[SR_EXL]        = sr_exl;
                rdata[SR_IE]         = sr_ie;
            end
            REG_CAUSE: begin
                rdata[CAUSE_BD]                 = cause_bd;
                rdata[CAUSE_IP_LO +: 6]         = cause_ip;
                rdata[CAUSE_EXC_LO +: EXCCODE_W] = cause_exc;
            end
            REG_EPC:     rdata = epc;
            REG_PRID:    rdata = PRID;
`ifdef CP0_COUNT_EN
            REG_COUNT:   rdata = count;
            REG_COMPARE: rdata = compare;
`endif
            default:     rdata = '0;
        endcase
    end

endmodule
